// File: rtl/alu_flags_reg.sv
// -----------------------------------------------------------------------------
// alu_flags_reg
//   NZCV status-flag register for the ALU datapath. Derives N/Z/C/V from the
//   ALU result, adder carry-out and operand sign bits, and latches them on a
//   flag-setting op. Also evaluates a 4-bit condition code against the latched
//   flags for predicated execution.
//
// Parameters
//   WIDTH     ALU result width in bits (>= 2)
//   ARITH_OP  alu_control[3:1] value marking add/sub; alu_control[0]=1 is sub
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   valid_in       ALU result/control valid this cycle
//   flags_we       S-bit: update flags when valid_in=1
//   alu_control    ALU op code
//   alu_result     ALU result
//   carry_in       raw adder carry-out
//   a_msb, b_msb   operand sign bits (b as presented to the ALU, pre-inversion)
//   cond_valid     condition evaluation request
//   cond           condition code (EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL NV)
//   flags_out      registered {N,Z,C,V}
//   cond_pass      registered condition result (0 whenever cond_vld_out=0)
//   cond_vld_out   cond_pass valid, one cycle after cond_valid
//
// Optional feature (macro STICKY_OVF_EN)
//   q_clr          synchronous clear of the sticky overflow flag
//   q_flag         sticky overflow; set the cycle after an update writes V=1,
//                  held until q_clr; a same-cycle set beats the clear
//
// Handshake: valid_in is a qualifier only (no ready, never stalls). When
// valid_in=0 every other update input is ignored; when valid_in=1 and
// flags_we=1 the flags are written at that clock edge. cond_valid is likewise
// accepted every cycle and answered exactly one cycle later.
// -----------------------------------------------------------------------------
module alu_flags_reg #(
  parameter int          WIDTH    = 32,
  parameter logic [2:0]  ARITH_OP = 3'b100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             flags_we,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             carry_in,
  input  logic             a_msb,
  input  logic             b_msb,
  input  logic             cond_valid,
  input  logic [3:0]       cond,
  output logic [3:0]       flags_out,
  output logic             cond_pass,
  output logic             cond_vld_out
`ifdef STICKY_OVF_EN
  ,
  input  logic             q_clr,
  output logic             q_flag
`endif
);

  logic flag_n, flag_z, flag_c, flag_v;
  logic upd;
  logic is_arith;
  logic is_sub;
  logic res_msb;
  logic v_calc;
  logic cond_eval;

  assign upd      = valid_in & flags_we;
  assign is_arith = (alu_control[3:1] == ARITH_OP);
  assign is_sub   = alu_control[0];
  assign res_msb  = alu_result[WIDTH-1];

  // b_msb is the un-inverted operand, so subtraction overflows when the
  // operand signs differ and the result sign departs from A.
  always_comb begin
    v_calc = 1'b0;
    if (is_sub) v_calc = (a_msb != b_msb) & (res_msb != a_msb);
    else        v_calc = (a_msb == b_msb) & (res_msb != a_msb);
  end

  // N and Z follow every op; C and V only change on add/sub and otherwise
  // keep their earlier values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else if (upd) begin
      flag_n <= res_msb;
      flag_z <= (alu_result == '0);
      if (is_arith) begin
        flag_c <= carry_in;
        flag_v <= v_calc;
      end
    end
  end

  assign flags_out = {flag_n, flag_z, flag_c, flag_v};

  // Evaluated from the registered flags, so an update in the same cycle is
  // not seen by the condition (old flags win).
  always_comb begin
    cond_eval = 1'b0;
    unique case (cond)
      4'h0: cond_eval = flag_z;
      4'h1: cond_eval = ~flag_z;
      4'h2: cond_eval = flag_c;
      4'h3: cond_eval = ~flag_c;
      4'h4: cond_eval = flag_n;
      4'h5: cond_eval = ~flag_n;
      4'h6: cond_eval = flag_v;
      4'h7: cond_eval = ~flag_v;
      4'h8: cond_eval = flag_c & ~flag_z;
      4'h9: cond_eval = ~flag_c | flag_z;
      4'hA: cond_eval = (flag_n == flag_v);
      4'hB: cond_eval = (flag_n != flag_v);
      4'hC: cond_eval = ~flag_z & (flag_n == flag_v);
      4'hD: cond_eval = flag_z | (flag_n != flag_v);
      4'hE: cond_eval = 1'b1;
      4'hF: cond_eval = 1'b0;
      default: cond_eval = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond_pass    <= 1'b0;
      cond_vld_out <= 1'b0;
    end else begin
      cond_pass    <= cond_valid & cond_eval;
      cond_vld_out <= cond_valid;
    end
  end

`ifdef STICKY_OVF_EN
  // Only an add/sub update actually writes V; a set in the same cycle as
  // q_clr takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_flag <= 1'b0;
    end else if (upd & is_arith & v_calc) begin
      q_flag <= 1'b1;
    end else if (q_clr) begin
      q_flag <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_flags_reg.sv
module tb_alu_flags_reg;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             valid_in;
  logic             flags_we;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] alu_result;
  logic             carry_in;
  logic             a_msb;
  logic             b_msb;
  logic             cond_valid;
  logic [3:0]       cond;
  logic [3:0]       flags_out;
  logic             cond_pass;
  logic             cond_vld_out;
`ifdef STICKY_OVF_EN
  logic             q_clr;
  logic             q_flag;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] exp_q[$];

  alu_flags_reg #(.WIDTH(WIDTH), .ARITH_OP(3'b100)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .flags_we     (flags_we),
    .alu_control  (alu_control),
    .alu_result   (alu_result),
    .carry_in     (carry_in),
    .a_msb        (a_msb),
    .b_msb        (b_msb),
    .cond_valid   (cond_valid),
    .cond         (cond),
    .flags_out    (flags_out),
    .cond_pass    (cond_pass),
    .cond_vld_out (cond_vld_out)
`ifdef STICKY_OVF_EN
    ,
    .q_clr        (q_clr),
    .q_flag       (q_flag)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference condition table, written out from the code list.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    valid_in    = 1'b0;
    flags_we    = 1'b0;
    alu_control = 4'h0;
    alu_result  = '0;
    carry_in    = 1'b0;
    a_msb       = 1'b0;
    b_msb       = 1'b0;
    cond_valid  = 1'b0;
    cond        = 4'h0;
`ifdef STICKY_OVF_EN
    q_clr       = 1'b0;
`endif
  endtask

  // Inputs are set 1 time unit after an edge; results sampled 1 unit after the next.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_upd(input logic v, input logic we, input logic [3:0] ctl,
                           input logic [WIDTH-1:0] res, input logic cy,
                           input logic am, input logic bm);
    valid_in = v; flags_we = we; alu_control = ctl; alu_result = res;
    carry_in = cy; a_msb = am; b_msb = bm;
  endtask

  // Force the flags to an exact NZCV pattern using an add (N and Z may not both be 1).
  task automatic load_flags(input logic [3:0] f);
    logic [WIDTH-1:0] res;
    logic rm;
    res = f[3] ? 8'h80 : (f[2] ? 8'h00 : 8'h01);
    rm  = res[WIDTH-1];
    // add V=1 needs equal operand signs opposite the result sign
    drive_upd(1'b1, 1'b1, 4'b1000, res, f[1], f[0] ? !rm : rm, f[0] ? !rm : rm);
    cycle();
    idle_inputs();
  endtask

  typedef struct {
    logic             v;
    logic             we;
    logic [3:0]       ctl;
    logic [WIDTH-1:0] res;
    logic             cy;
    logic             am;
    logic             bm;
    logic [3:0]       exp_flags;
    string            name;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [3:0] e;
    rst_n = 1'b0;
    idle_inputs();

    vecs[0] = '{1, 1, 4'b1000, 8'h80, 0, 0, 0, 4'b1001, "add_7f_01"};
    vecs[1] = '{1, 1, 4'b1001, 8'h00, 1, 0, 0, 4'b0110, "sub_05_05"};
    vecs[2] = '{1, 1, 4'b0000, 8'h01, 0, 0, 0, 4'b0010, "and_c_held"};
    vecs[3] = '{1, 0, 4'b1000, 8'h80, 0, 0, 0, 4'b0010, "we0_hold"};
    vecs[4] = '{0, 1, 4'b1000, 8'h00, 1, 1, 1, 4'b0010, "valid0_hold"};
    vecs[5] = '{1, 1, 4'b1001, 8'h7F, 1, 1, 0, 4'b0011, "sub_ovf"};
    vecs[6] = '{1, 1, 4'b0110, 8'h80, 0, 0, 0, 4'b1011, "logic_cv_held"};
    vecs[7] = '{1, 1, 4'b1000, 8'h00, 1, 1, 1, 4'b0111, "add_neg_ovf"};
    vecs[8] = '{1, 1, 4'b1001, 8'hFF, 0, 1, 1, 4'b1000, "sub_no_ovf"};
    vecs[9] = '{1, 1, 4'b1010, 8'h01, 1, 1, 1, 4'b0000, "nonarith_101"};

    // reset state
    #12;
    check("reset_flags", flags_out, 4'b0000);
    check("reset_cond", {2'b00, cond_pass, cond_vld_out}, 4'b0000);
`ifdef STICKY_OVF_EN
    check("reset_qflag", {3'b000, q_flag}, 4'b0000);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // table-driven update vectors, applied back-to-back
    for (int i = 0; i < 10; i++) begin
      drive_upd(vecs[i].v, vecs[i].we, vecs[i].ctl, vecs[i].res, vecs[i].cy, vecs[i].am, vecs[i].bm);
      exp_q.push_back(vecs[i].exp_flags);
      cycle();
      e = exp_q.pop_front();
      check(vecs[i].name, flags_out, e);
    end
    idle_inputs();

    // EQ on 0110, then EQ in the same cycle as an update clearing Z
    load_flags(4'b0110);
    check("load_0110", flags_out, 4'b0110);
    cond_valid = 1'b1; cond = 4'h0;
    cycle();
    check("eq_pass", {2'b00, cond_pass, cond_vld_out}, 4'b0011);
    drive_upd(1'b1, 1'b1, 4'b0000, 8'h01, 1'b0, 1'b0, 1'b0);
    cond_valid = 1'b1; cond = 4'h0;
    cycle();
    idle_inputs();
    check("eq_old_flags", {2'b00, cond_pass, cond_vld_out}, 4'b0011);
    check("eq_upd_flags", flags_out, 4'b0010);
    cycle();
    check("cond_idle", {2'b00, cond_pass, cond_vld_out}, 4'b0000);

    // condition sweep over every reachable flag pattern
    for (int p = 0; p < 16; p++) begin
      logic [3:0] f;
      f = p[3:0];
      if (f[3] && f[2]) continue;
      load_flags(f);
      check("sweep_flags", flags_out, f);
      for (int c = 0; c < 16; c++) begin
        logic [3:0] cc;
        cc = c[3:0];
        cond_valid = 1'b1; cond = cc;
        cycle();
        check($sformatf("cond_%h_f%b", cc, f), {2'b00, cond_pass, cond_vld_out},
              {2'b00, ref_cond(cc, f), 1'b1});
      end
      idle_inputs();
    end

    // asynchronous reset mid-stream
    load_flags(4'b1011);
    cond_valid = 1'b1; cond = 4'hE;
    cycle();
    idle_inputs();
    check("pre_rst_flags", flags_out, 4'b1011);
    check("pre_rst_cond", {2'b00, cond_pass, cond_vld_out}, 4'b0011);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_flags", flags_out, 4'b0000);
    check("async_rst_cond", {2'b00, cond_pass, cond_vld_out}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

`ifdef STICKY_OVF_EN
    // sticky overflow: set, survive V-clearing add, set beats clear, clear alone
    drive_upd(1'b1, 1'b1, 4'b1000, 8'h80, 1'b0, 1'b0, 1'b0);
    cycle();
    check("sticky_set", {3'b000, q_flag}, 4'b0001);
    drive_upd(1'b1, 1'b1, 4'b1000, 8'h02, 1'b0, 1'b0, 1'b0);
    cycle();
    check("sticky_hold", {3'b000, q_flag}, 4'b0001);
    drive_upd(1'b1, 1'b1, 4'b1000, 8'h80, 1'b0, 1'b0, 1'b0);
    q_clr = 1'b1;
    cycle();
    check("sticky_set_wins", {3'b000, q_flag}, 4'b0001);
    idle_inputs();
    q_clr = 1'b1;
    cycle();
    idle_inputs();
    check("sticky_clear", {3'b000, q_flag}, 4'b0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
